// File: rtl/issue_pkg.sv
// Shared types and constants for the integer issue queue.
package issue_pkg;

    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef struct packed {
        logic              valid;
        logic [2:0]        opcode;
        logic [4:0]        shfamt;
        logic [TAG_W-1:0]  rd_tag;
        logic [DATA_W-1:0] rs_data;
        logic [TAG_W-1:0]  rs_tag;
        logic              rs_rdy;
        logic [DATA_W-1:0] rt_data;
        logic [TAG_W-1:0]  rt_tag;
        logic              rt_rdy;
    } iq_entry_t;

endpackage

// File: rtl/iq_select.sv
// Oldest-first fixed-priority picker: index 0 wins.
module iq_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] grant,
    output logic             found
);

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_queue_int.sv
// Integer reservation station: compacting age-ordered queue with CDB wakeup and a registered issue stage.
// Optional ISSUEQ_CDB_WAKEUP_BYPASS_EN makes an entry completed by the current CDB select-eligible that cycle.
module issue_queue_int #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = issue_pkg::TAG_W,
    parameter int DATA_W = issue_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Dispatch_en_integer,
    input  logic [2:0]        Dispatch_opcode,
    input  logic [4:0]        Dispatch_shfamt,
    input  logic [TAG_W-1:0]  Dispatch_rd_tag,
    input  logic [DATA_W-1:0] Dispatch_rs_data,
    input  logic [DATA_W-1:0] Dispatch_rt_data,
    input  logic [TAG_W-1:0]  Dispatch_rs_tag,
    input  logic [TAG_W-1:0]  Dispatch_rt_tag,
    input  logic              Dispatch_rs_valid,
    input  logic              Dispatch_rt_valid,
    output logic              Issueque_full,
    input  logic              Cdb_valid,
    input  logic [TAG_W-1:0]  Cdb_rd_tag,
    input  logic [DATA_W-1:0] Cdb_data,
    input  logic              Flush,
    input  logic              Issue_ready,
    output logic              Issue_valid,
    output logic [2:0]        Issue_opcode,
    output logic [4:0]        Issue_shfamt,
    output logic [DATA_W-1:0] Issue_rs_data,
    output logic [DATA_W-1:0] Issue_rt_data,
    output logic [TAG_W-1:0]  Issue_rd_tag
);
    import issue_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    iq_entry_t        q      [DEPTH];
    iq_entry_t        q_wake [DEPTH];
    iq_entry_t        q_next [DEPTH];
    iq_entry_t        disp_entry;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] wr_idx;
    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] grant;
    logic             found;
    logic             out_free;
    logic             issue_fire;
    logic             disp_acc;
    logic [IDX_W-1:0] sel_idx;

    assign Issueque_full = (count == CNT_W'(DEPTH));
    assign disp_acc      = Dispatch_en_integer && !Issueque_full;
    assign out_free      = !Issue_valid || Issue_ready;
    assign issue_fire    = found && out_free;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_wake[i] = q[i];
            if (q[i].valid && Cdb_valid) begin
                if (!q[i].rs_rdy && q[i].rs_tag == Cdb_rd_tag) begin
                    q_wake[i].rs_data = Cdb_data;
                    q_wake[i].rs_rdy  = 1'b1;
                end
                if (!q[i].rt_rdy && q[i].rt_tag == Cdb_rd_tag) begin
                    q_wake[i].rt_data = Cdb_data;
                    q_wake[i].rt_rdy  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
`ifdef ISSUEQ_CDB_WAKEUP_BYPASS_EN
            ready_vec[i] = q_wake[i].valid && q_wake[i].rs_rdy && q_wake[i].rt_rdy;
`else
            ready_vec[i] = q[i].valid && q[i].rs_rdy && q[i].rt_rdy;
`endif
        end
    end

    iq_select #(.DEPTH(DEPTH)) u_select (
        .ready (ready_vec),
        .grant (grant),
        .found (found)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) sel_idx = IDX_W'(i);
        end
    end

    // An operand not supplied by dispatch may still be on the CDB this very cycle.
    always_comb begin
        disp_entry        = '0;
        disp_entry.valid  = 1'b1;
        disp_entry.opcode = Dispatch_opcode;
        disp_entry.shfamt = Dispatch_shfamt;
        disp_entry.rd_tag = Dispatch_rd_tag;
        disp_entry.rs_tag = Dispatch_rs_tag;
        disp_entry.rt_tag = Dispatch_rt_tag;
        if (Dispatch_rs_valid) begin
            disp_entry.rs_data = Dispatch_rs_data;
            disp_entry.rs_rdy  = 1'b1;
        end else if (Cdb_valid && Cdb_rd_tag == Dispatch_rs_tag) begin
            disp_entry.rs_data = Cdb_data;
            disp_entry.rs_rdy  = 1'b1;
        end
        if (Dispatch_rt_valid) begin
            disp_entry.rt_data = Dispatch_rt_data;
            disp_entry.rt_rdy  = 1'b1;
        end else if (Cdb_valid && Cdb_rd_tag == Dispatch_rt_tag) begin
            disp_entry.rt_data = Cdb_data;
            disp_entry.rt_rdy  = 1'b1;
        end
    end

    // Entries above the issued one slide down; the new op lands just past the survivors.
    always_comb begin
        wr_idx     = count - CNT_W'(issue_fire);
        count_next = count + CNT_W'(disp_acc) - CNT_W'(issue_fire);
        for (int i = 0; i < DEPTH; i++) begin
            int src;
            src = i;
            if (issue_fire && i >= int'(sel_idx)) src = i + 1;
            if (src < DEPTH) q_next[i] = q_wake[src];
            else             q_next[i] = '0;
            if (disp_acc && CNT_W'(i) == wr_idx) q_next[i] = disp_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || Flush) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            count         <= '0;
            Issue_valid   <= 1'b0;
            Issue_opcode  <= '0;
            Issue_shfamt  <= '0;
            Issue_rs_data <= '0;
            Issue_rt_data <= '0;
            Issue_rd_tag  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q[i] <= q_next[i];
            count <= count_next;
            if (issue_fire) begin
                Issue_valid   <= 1'b1;
                Issue_opcode  <= q_wake[sel_idx].opcode;
                Issue_shfamt  <= q_wake[sel_idx].shfamt;
                Issue_rs_data <= q_wake[sel_idx].rs_data;
                Issue_rt_data <= q_wake[sel_idx].rt_data;
                Issue_rd_tag  <= q_wake[sel_idx].rd_tag;
            end else if (Issue_ready) begin
                Issue_valid <= 1'b0;
            end
        end
    end

endmodule
